// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, byte-lane
// width, the request bundle and the request error decode.
package dmem_responder_pkg;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic [31:0]       addr;
    logic [MASK_W-1:0] mask;
    logic [31:0]       wdata;
    logic              ren;
    logic              wen;
  } req_t;

  // Bad request: word index past the end, read and write together, or a
  // write that enables no lane.
  function automatic logic req_err(req_t r, int unsigned depth);
    return ({2'b00, r.addr[31:2]} >= depth) || (r.ren && r.wen) ||
           (r.wen && (r.mask == '0));
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem request/response bus between the memory-stage requester (master)
// and the responder (slave).
//   addr/mask/ren/wen/wdata : request, held by the master until accepted
//   ready                   : accept when (ren|wen) & ready
//   vld/rdata/err           : one-cycle response pulse
interface dmem_responder_if;
  import dmem_responder_pkg::*;
  logic [31:0]       addr;
  logic [MASK_W-1:0] mask;
  logic              ren;
  logic              wen;
  logic [31:0]       wdata;
  logic              ready;
  logic              vld;
  logic [31:0]       rdata;
  logic              err;

  modport master (output addr, mask, ren, wen, wdata,
                  input  ready, vld, rdata, err);
  modport slave  (input  addr, mask, ren, wen, wdata,
                  output ready, vld, rdata, err);
endinterface

// File: rtl/dmem_responder_sram.sv
// Single-port synchronous RAM, 32-bit words with 4 byte enables.
//   clk   : clock
//   en    : access enable
//   we    : per-lane write enables (all zero = read)
//   addr  : word index
//   wdata : write data, lane aligned
//   rdata : registered read word, updated one cycle after an enabled access
module dmem_responder_sram #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++)
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one dmem request at a time, waits LATENCY
// cycles, performs a byte-masked write or a full-word read, and pulses vld.
//   clk : clock
//   rst : synchronous active-high reset (RAM contents are kept)
//   bus : dmem bus, slave side
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic         clk,
  input  logic         rst,
  dmem_responder_if.slave bus
);
  localparam int LAT   = (LATENCY < 1) ? 1 : LATENCY;
  localparam int CNT_W = $clog2(LAT + 1);
  localparam int AW    = $clog2(DEPTH_WORDS);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [AW-1:0]     req_word;
  logic [MASK_W-1:0] req_mask;
  logic [31:0]       req_wdata;
  logic              req_ren;
  logic              req_wen;
  logic              req_bad;
  logic              rd_ok;
  logic              ready;
  logic              vld;
  logic              err;
  logic [31:0]       sram_rdata;

  req_t in_req;
  assign in_req = '{addr: bus.addr, mask: bus.mask, wdata: bus.wdata,
                    ren: bus.ren, wen: bus.wen};

  // Byte offset is not used; the requester selects sub-words itself.
  logic unused_lo;
  assign unused_lo = ^in_req.addr[1:0];

  logic accept, fire;
  assign accept = ready & (bus.ren | bus.wen);
  assign fire   = (state == S_WAIT) && (cnt == '0);

  // Gated by rst so a transaction dropped by reset never reaches the RAM.
  dmem_responder_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk   (clk),
    .en    (fire & ~req_bad & ~rst),
    .we    (req_wen ? req_mask : 4'b0000),
    .addr  (req_word),
    .wdata (req_wdata),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_word  <= '0;
      req_mask  <= '0;
      req_wdata <= '0;
      req_ren   <= 1'b0;
      req_wen   <= 1'b0;
      req_bad   <= 1'b0;
      rd_ok     <= 1'b0;
      ready     <= 1'b0;
      vld       <= 1'b0;
      err       <= 1'b0;
    end else begin
      vld   <= 1'b0;
      err   <= 1'b0;
      rd_ok <= 1'b0;
      case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            req_word  <= in_req.addr[AW+1:2];
            req_mask  <= in_req.mask;
            req_wdata <= in_req.wdata;
            req_ren   <= in_req.ren;
            req_wen   <= in_req.wen;
            req_bad   <= req_err(in_req, DEPTH_WORDS);
            cnt       <= CNT_W'(LAT - 1);
            state     <= S_WAIT;
            ready     <= 1'b0;
          end else begin
            state <= S_IDLE;
            ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // RAM access happens on this edge; its read word lands with vld.
            vld   <= 1'b1;
            err   <= req_bad;
            rd_ok <= req_ren & ~req_bad;
            state <= S_RESP;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = ready;
  assign bus.vld   = vld;
  assign bus.err   = err;
  assign bus.rdata = rd_ok ? sram_rdata : 32'h0;
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int DEPTH = 64;
  localparam int LATS [3] = '{1, 3, 4};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          sel = 0;
  logic [31:0] addr = '0;
  logic [3:0]  mask = '0;
  logic [31:0] wdata = '0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic        rdy, vld, err;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mdl [3][DEPTH];
  logic [31:0] obs_rdata;
  time         acc_t;

  always #5 clk = ~clk;

  dmem_responder_if b1 ();
  dmem_responder_if b3 ();
  dmem_responder_if b4 ();

  assign b1.addr = addr;  assign b1.mask = mask;  assign b1.wdata = wdata;
  assign b3.addr = addr;  assign b3.mask = mask;  assign b3.wdata = wdata;
  assign b4.addr = addr;  assign b4.mask = mask;  assign b4.wdata = wdata;
  assign b1.ren = (sel == 0) & ren;  assign b1.wen = (sel == 0) & wen;
  assign b3.ren = (sel == 1) & ren;  assign b3.wen = (sel == 1) & wen;
  assign b4.ren = (sel == 2) & ren;  assign b4.wen = (sel == 2) & wen;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

  always_comb begin
    rdy = b1.ready; vld = b1.vld; err = b1.err; rdata = b1.rdata;
    case (sel)
      1: begin rdy = b3.ready; vld = b3.vld; err = b3.err; rdata = b3.rdata; end
      2: begin rdy = b4.ready; vld = b4.vld; err = b4.err; rdata = b4.rdata; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (dut %0d, t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  // One request on DUT s; called at a negedge, returns at the response negedge.
  task automatic txn(input int s, input bit r, input bit w, input logic [31:0] a,
                     input logic [3:0] m, input logic [31:0] d);
    int lat, t;
    logic [29:0] idx;
    logic e;
    logic [31:0] exp_rd;
    lat = LATS[s];
    sel = s; addr = a; mask = m; wdata = d; ren = r; wen = w;
    #1;
    t = 0;
    while (!rdy && t < 50) begin @(negedge clk); #1; t++; end
    if (!rdy) begin
      check("ready_timeout", {31'b0, rdy}, 32'h1);
      ren = 1'b0; wen = 1'b0;
      return;
    end
    idx = a[31:2];
    e = (idx >= DEPTH) || (r && w) || (w && m == 4'b0000);
    exp_rd = (r && !e) ? mdl[s][idx] : 32'h0;
    if (w && !e)
      for (int b = 0; b < 4; b++)
        if (m[b]) mdl[s][idx][8*b +: 8] = d[8*b +: 8];
    @(posedge clk);
    acc_t = $time;
    for (int j = 0; j <= lat; j++) begin
      @(negedge clk);
      if (j == 0) begin ren = 1'b0; wen = 1'b0; end
      check("rdy_vld", {30'b0, rdy, vld}, (j == lat) ? 32'h3 : 32'h0);
    end
    check("err", {31'b0, err}, {31'b0, e});
    check("rdata", rdata, exp_rd);
    obs_rdata = rdata;
  endtask

  initial begin
    time t0;
    // Reset state
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check("rst_out", {29'b0, rdy, vld, err}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check("post_rst_ready", {31'b0, rdy}, 32'h1);
    end
    @(negedge clk);

    // Write then read at LATENCY=1
    txn(0, 0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
    txn(0, 1, 0, 32'h10, 4'hF, 32'h0);
    check("t1_rd", obs_rdata, 32'hDEADBEEF);

    // Fill words 0..15 of every DUT (word 4 of DUT 0 stays 0xDEADBEEF)
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 16; i++)
        if (!(s == 0 && i == 4)) txn(s, 0, 1, i * 4, 4'hF, $urandom);

    // Byte-masked write
    txn(0, 0, 1, 32'h20, 4'hF, 32'h11223344);
    txn(0, 0, 1, 32'h20, 4'b0100, 32'h00AA0000);
    txn(0, 1, 0, 32'h20, 4'h0, 32'h0);
    check("t2_mask", obs_rdata, 32'h11AA3344);

    // LATENCY=3 back-to-back reads: one accept per 4 cycles
    txn(1, 1, 0, 32'h0, 4'hF, 32'h0);
    t0 = acc_t;
    for (int k = 1; k < 4; k++) begin
      txn(1, 1, 0, k * 4, 4'hF, 32'h0);
      check("t3_period", 32'(acc_t - t0), 32'd40);
      t0 = acc_t;
    end

    // Error cases, RAM unchanged afterwards
    txn(0, 1, 0, 4 * DEPTH, 4'hF, 32'h0);
    txn(0, 1, 1, 32'h10, 4'hF, 32'h12345678);
    txn(0, 0, 1, 32'h10, 4'h0, 32'h87654321);
    txn(0, 1, 0, 32'h10, 4'h0, 32'h0);
    check("t4_unchanged", obs_rdata, 32'hDEADBEEF);

    // Reset during WAIT at LATENCY=4: write dropped
    sel = 2; addr = 32'h14; mask = 4'hF; wdata = ~mdl[2][5]; wen = 1'b1;
    #1;
    check("t5_ready", {31'b0, rdy}, 32'h1);
    @(posedge clk);
    @(negedge clk); wen = 1'b0;
    check("t5_vld0", {31'b0, vld}, 32'h0);
    @(negedge clk); rst = 1'b1;
    check("t5_vld1", {31'b0, vld}, 32'h0);
    @(negedge clk); rst = 1'b0;
    check("t5_in_rst", {30'b0, rdy, vld}, 32'h0);
    @(negedge clk);
    check("t5_after_rst", {30'b0, rdy, vld}, 32'h2);
    txn(2, 1, 0, 32'h14, 4'hF, 32'h0);

    // Idle bus
    sel = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_idle", {30'b0, rdy, vld}, 32'h2);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 80; i++) begin
      int s;
      bit r, w;
      logic [31:0] a;
      s = $urandom_range(0, 2);
      case ($urandom_range(0, 9))
        0:       begin r = 1; w = 1; end
        1, 2, 3: begin r = 0; w = 1; end
        default: begin r = 1; w = 0; end
      endcase
      if ($urandom_range(0, 9) == 0)
        a = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFC : (4 * DEPTH + 4 * $urandom_range(0, 7));
      else
        a = 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      txn(s, r, w, a, 4'($urandom_range(0, 15)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
